instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Responder side of the control unit's program-counter and instruction-register command interface.
- Owns the PC register, the instruction-memory fetch handshake and the IR register; drives IR back to the control unit for decode.
- Consumes PC_CLR, PR_ID (IR load / fetch) and PC_IC; also PC_LD/PC_TGT, reserved for branch/jump support.
- Sits between the control unit and the 16-bit instruction memory.

Parameters:
- PC_W, 8, program counter and instruction address width (256-word instruction memory).
- TIMEOUT, 15, max cycles in REQ without IM_ACK before the fetch is aborted (must be ≥1).
- NOOP_WORD, 16'h0000, value loaded into IR on an aborted fetch.

Ports:
- Clock, in, 1, single system clock; all state updates on posedge.
- Reset, in, 1, synchronous, active-high.
- PC_CLR, in, 1, clear PC to 0.
- PR_ID, in, 1, start fetch of the word at PC into IR.
- PC_IC, in, 1, increment PC.
- PC_LD, in, 1, load PC from PC_TGT.
- PC_TGT, in, PC_W, PC load target.
- IM_ADDR, out, PC_W, instruction memory address (valid while IM_REQ=1).
- IM_REQ, out, 1, instruction memory read request.
- IM_RDATA, in, 16, instruction memory read data (valid when IM_ACK=1).
- IM_ACK, in, 1, instruction memory read acknowledge.
- IR, out, 16, instruction register.
- IR_VALID, out, 1, IR holds a completed fetch.
- PC, out, PC_W, current program counter.
- FETCH_BUSY, out, 1, a fetch is in flight.
- CMD_ERR, out, 1, sticky error flag (PR_ID while busy, or fetch timeout).

Behaviour:
- Reset: only Clock and Reset are named as the codebase does; Reset is synchronous, active-high. In the cycle after Reset is sampled high: PC=0, IR=NOOP_WORD, IR_VALID=0, IM_REQ=0, IM_ADDR=0, FETCH_BUSY=0, CMD_ERR=0, FSM=IDLE. Reset overrides all other inputs, including mid-fetch; any later IM_ACK is ignored while in IDLE.
- PC update, registered. Priority PC_CLR > PC_LD > PC_IC; one action per cycle:
  - PC_CLR: PC<=0.
  - PC_LD: PC<=PC_TGT.
  - PC_IC: PC<=PC+1 mod 2^PC_W; 0xFF wraps to 0x00 at PC_W=8.
  - PC commands are honoured in every FSM state.
- FSM states:
  - IDLE: FETCH_BUSY=0, IM_REQ=0. PR_ID=1 → latch FADDR<=PC (pre-update value of the same cycle), IR_VALID<=0, timer<=0, go to REQ.
  - REQ: IM_REQ=1, IM_ADDR=FADDR, FETCH_BUSY=1.
    - IM_ACK=1 → IR<=IM_RDATA, IR_VALID<=1, go to IDLE.
    - Else timer increments. When timer reaches TIMEOUT without an ACK: IR<=NOOP_WORD, IR_VALID<=1, CMD_ERR<=1, go to IDLE.
- Latency:
  - IM_REQ rises one cycle after PR_ID is sampled.
  - IR/IR_VALID update on the edge that samples IM_ACK.
  - Zero-wait memory (ACK on first REQ cycle) gives PR_ID-to-IR_VALID = 2 cycles.
- Fetch address is frozen in FADDR. PC changes during REQ do not alter IM_ADDR or the word being fetched.
- PR_ID while in REQ: ignored, no restart; CMD_ERR<=1.
- PC_CLR also clears IR_VALID, unless an ACK completes in the same cycle, in which case IR_VALID<=1.
- IM_ACK while in IDLE: ignored.
- CMD_ERR clears only on Reset.
- IR holds its value until the next completed or aborted fetch.

Decomposition:
- Shared package (cpu_pkg):
  - INSTR_W=16 and the default PC_W.
  - Opcode constants, including NOOP_WORD; these are shared with the control unit decode.
  - Enumerated type fetch_state_t {IDLE, REQ}.
- One natural sub-module, pc_reg: the PC register with clr/ld/inc priority logic and wrap. The FSM, timer and IR live in the top module.

Test Plan:
- Reset with PR_ID=1, PC_IC=1 held → after the edge PC=0x00, IR=0x0000, IR_VALID=0, IM_REQ=0, CMD_ERR=0.
- PC=0x05; PR_ID pulse; memory ACKs on the first REQ cycle with 0x1234 → IM_ADDR=0x05 while IM_REQ=1; IR=0x1234, IR_VALID=1 exactly 2 cycles after PR_ID.
- PC=0x10; PR_ID, then PC_IC during a 3-wait-state fetch → IM_ADDR stays 0x10; PC=0x11; IR = data at 0x10.
- PC=0xFF; PC_IC → PC=0x00. Same cycle PC_CLR=1, PC_LD=1 (PC_TGT=0x40), PC_IC=1 → PC=0x00; next cycle PC_LD only → PC=0x40.
- Memory never ACKs → after TIMEOUT=15 REQ cycles: IR=0x0000, IR_VALID=1, CMD_ERR=1, FSM back in IDLE, IM_REQ=0.
- Second PR_ID during REQ → no restart; CMD_ERR=1; first fetch completes normally. Reset asserted mid-REQ → IM_REQ=0 next cycle; a late IM_ACK leaves IR=0x0000, IR_VALID=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths, opcode constants and fetch FSM state type
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int INSTR_W      = 16;
  localparam int DEFAULT_PC_W = 8;

  // Opcode words shared with the control unit decoder
  localparam logic [INSTR_W-1:0] OP_NOOP = 16'h0000;
  localparam logic [INSTR_W-1:0] OP_HALT = 16'hF000;
  localparam logic [INSTR_W-1:0] OP_JMP  = 16'h8000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// pc_reg : program counter with clear > load > increment priority, wraps
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            clr,
  input  logic            ld,
  input  logic            inc,
  input  logic [PC_W-1:0] tgt,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc <= '0;
    end else if (clr) begin
      r_pc <= '0;
    end else if (ld) begin
      r_pc <= tgt;
    end else if (inc) begin
      // natural modulo-2^PC_W wrap
      r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  assign pc = r_pc;

endmodule : pc_reg

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC, instruction-memory fetch handshake and IR register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                 PC_W      = DEFAULT_PC_W,
  parameter int                 TIMEOUT   = 15,
  parameter logic [INSTR_W-1:0] NOOP_WORD = OP_NOOP
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               PC_CLR,
  input  logic               PR_ID,
  input  logic               PC_IC,
  input  logic               PC_LD,
  input  logic [PC_W-1:0]    PC_TGT,
  output logic [PC_W-1:0]    IM_ADDR,
  output logic               IM_REQ,
  input  logic [INSTR_W-1:0] IM_RDATA,
  input  logic               IM_ACK,
  output logic [INSTR_W-1:0] IR,
  output logic               IR_VALID,
  output logic [PC_W-1:0]    PC,
  output logic               FETCH_BUSY,
  output logic               CMD_ERR
);

  localparam int                  c_TIMER_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

  fetch_state_t         r_state;
  logic [PC_W-1:0]      r_faddr;
  logic [c_TIMER_W-1:0] r_timer;
  logic [INSTR_W-1:0]   r_ir;
  logic                 r_ir_valid;
  logic                 r_cmd_err;
  logic [PC_W-1:0]      w_pc;
  logic                 w_start;
  logic                 w_ack_done;
  logic                 w_timeout;

  pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (PC_CLR),
    .ld    (PC_LD),
    .inc   (PC_IC),
    .tgt   (PC_TGT),
    .pc    (w_pc)
  );

  assign w_start    = (r_state == IDLE) && PR_ID;
  assign w_ack_done = (r_state == REQ) && IM_ACK;
  assign w_timeout  = (r_state == REQ) && !IM_ACK && (r_timer == c_TIMER_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_faddr    <= '0;
      r_timer    <= '0;
      r_ir       <= NOOP_WORD;
      r_ir_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (PR_ID) begin
            r_faddr <= w_pc;
            r_timer <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (IM_ACK) begin
            r_ir    <= IM_RDATA;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_ir      <= NOOP_WORD;
            r_cmd_err <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + {{(c_TIMER_W-1){1'b0}}, 1'b1};
          end
          if (PR_ID) begin
            r_cmd_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A completing fetch wins over a PC clear in the same cycle
      if (w_ack_done || w_timeout) begin
        r_ir_valid <= 1'b1;
      end else if (w_start || PC_CLR) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign IM_REQ     = (r_state == REQ);
  assign FETCH_BUSY = (r_state == REQ);
  assign IM_ADDR    = (r_state == REQ) ? r_faddr : '0;
  assign IR         = r_ir;
  assign IR_VALID   = r_ir_valid;
  assign PC         = w_pc;
  assign CMD_ERR    = r_cmd_err;

endmodule : instr_fetch_unit

`default_nettype wire
